mux_arb_n_to_1: RTL and testbench
=================================

MUX_ARB_N_TO_1 -- requirements
Module: mux_arb_n_to_1

Interface
REQ-001 Parameter WIDTH, default 16, data width per channel in bits.
REQ-002 Parameter CHANNELS, default 8, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 3, select/pointer width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 I  in  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 REQ  in  CHANNELS  per-channel request; bit k = channel k data valid.
REQ-008 S  in  SEL_W  channel select, used in MODE=0 only.
REQ-009 MODE  in  1  0 = direct select, 1 = round-robin arbitration.
REQ-010 GNT  out  CHANNELS  one-hot or zero; combinational grant; channel k data is consumed this cycle.
REQ-011 Y  out  WIDTH  registered output data.
REQ-012 Y_VALID  out  1  Y holds a valid word.
REQ-013 Y_CH  out  SEL_W  source channel index of the word in Y.
REQ-014 Y_READY  in  1  downstream accepts Y this cycle when Y_VALID=1.

Function
REQ-015 LOAD = !Y_VALID | Y_READY; no grant SHALL be issued while LOAD=0 or RST=1.
REQ-016 MODE=0: GNT[S]=1 iff LOAD & REQ[S] & (S < CHANNELS); otherwise GNT=0.
REQ-017 MODE=1: winner = first k with REQ[k]=1, searching PTR, PTR+1, ... wrapping modulo CHANNELS; GNT[winner]=1 iff LOAD and any REQ bit is set.
REQ-018 PTR (SEL_W bits, internal) SHALL update to (winner+1) mod CHANNELS on every MODE=1 grant; wrap from CHANNELS-1 to 0.
REQ-019 PTR SHALL be left unchanged by MODE=0 grants and by cycles with no grant.
REQ-020 On any grant to channel k: at the edge, Y <= I[k], Y_CH <= k, Y_VALID <= 1 (1-cycle latency).
REQ-021 Y_VALID=1 & Y_READY=1 with no grant: Y_VALID <= 0 at the edge; Y and Y_CH hold their values.
REQ-022 Y_VALID=1 & Y_READY=1 with a grant in the same cycle: Y is replaced and Y_VALID stays 1, giving full throughput with no bubble.
REQ-023 Y_VALID=1 & Y_READY=0: Y, Y_CH and Y_VALID SHALL hold stable; GNT=0.
REQ-024 A MODE or S change SHALL take effect combinationally in the same cycle; no state is flushed.
REQ-025 Y_READY SHALL be ignored while Y_VALID=0.
REQ-026 GNT SHALL never have more than one bit set.

Reset
REQ-027 RST=1 at an edge: Y <= 0, Y_CH <= 0, Y_VALID <= 0, PTR <= 0.
REQ-028 While RST=1, GNT SHALL be 0 regardless of REQ, S or MODE.
REQ-029 Reset asserted while Y_VALID=1 SHALL discard the held word; the word is not delivered.
REQ-030 REQ may be asserted during reset; the first grant SHALL occur in the first cycle with RST=0.

Verification (WIDTH=16, CHANNELS=8; I0..I7 = DE,BC,9A,78,56,34,12,F0 hex)
REQ-031 Direct sweep: MODE=0, REQ=FF, Y_READY=1, S stepped 0..7 each cycle -> GNT = 01,02,..,80; one cycle later Y = 00DE,00BC,..,00F0, Y_VALID=1 continuously, Y_CH = S of previous cycle.
REQ-032 Round-robin: MODE=1, REQ=FF, Y_READY=1 for 10 cycles from reset -> Y_CH sequence 0,1,..,7,0,1; PTR wraps 7 -> 0.
REQ-033 Sparse round-robin: MODE=1, REQ=8'b1001_0100, Y_READY=1 -> grants cycle 2,4,7,2,...; Y = 009A,0056,00F0,009A,...
REQ-034 Backpressure: Y_VALID=1 with Y=0056, Y_READY=0 for 3 cycles, REQ=FF -> GNT=0 and Y=0056 held throughout; first Y_READY=1 cycle grants the next channel and Y updates at that edge.
REQ-035 Invalid select: MODE=0, S=7 with REQ[7]=0 -> GNT=0 and Y_VALID falls after the pending word is accepted; then REQ[7]=1 -> GNT=80, Y=00F0 next cycle.
REQ-036 Mid-operation reset: RST=1 for 1 cycle while Y_VALID=1 and PTR=5 -> Y=0000, Y_VALID=0, GNT=0 during reset; with MODE=1, REQ=FF after release, the first grant goes to channel 0.

Source files
------------

// File: rtl/mux_arb_n_to_1_if.sv
// Channel bus for the N-to-1 mux/arbiter: packed channel data and requests in,
// combinational grant back to the sources, registered word out with a ready handshake.
interface mux_arb_n_to_1_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic [CHANNELS*WIDTH-1:0] I;
  logic [CHANNELS-1:0]       REQ;
  logic [SEL_W-1:0]          S;
  logic                      MODE;
  logic [CHANNELS-1:0]       GNT;
  logic [WIDTH-1:0]          Y;
  logic                      Y_VALID;
  logic [SEL_W-1:0]          Y_CH;
  logic                      Y_READY;

  // Source/sink side: drives data, requests, select, mode and ready.
  modport master (
    output I, REQ, S, MODE, Y_READY,
    input  GNT, Y, Y_VALID, Y_CH
  );

  // Mux/arbiter side.
  modport slave (
    input  I, REQ, S, MODE, Y_READY,
    output GNT, Y, Y_VALID, Y_CH
  );
endinterface

// File: rtl/mux_arb_n_to_1.sv
// N-to-1 multiplexer/arbiter. MODE=0 picks the channel named by S, MODE=1
// arbitrates round-robin from an internal pointer. The chosen word lands in a
// single output register one cycle after its grant; a new grant is only issued
// when that register is empty or being drained in the same cycle.
module mux_arb_n_to_1 #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mux_arb_n_to_1_if.slave     bus
);

  logic [WIDTH-1:0]    r_y;
  logic                r_y_valid;
  logic [SEL_W-1:0]    r_y_ch;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load;
  logic                w_sel_ok;
  logic                w_rr_found;
  logic [SEL_W-1:0]    w_rr_winner;
  logic [SEL_W-1:0]    w_idx;
  logic                w_gnt_valid;
  logic [SEL_W-1:0]    w_gnt_ch;
  logic [CHANNELS-1:0] w_gnt;

  // Output register can take a new word when empty or drained this cycle.
  assign w_load   = !r_y_valid || bus.Y_READY;
  assign w_sel_ok = (int'(bus.S) < CHANNELS);

  // Round-robin search: walk from the pointer downwards in reverse so the
  // last hit written is the first requester at or after the pointer.
  always_comb begin
    w_rr_found  = 1'b0;
    w_rr_winner = '0;
    w_idx       = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      w_idx = SEL_W'((int'(r_ptr) + j) % CHANNELS);
      if (bus.REQ[w_idx]) begin
        w_rr_found  = 1'b1;
        w_rr_winner = w_idx;
      end else begin
        w_rr_found  = w_rr_found;
      end
    end
  end

  // Grant decision: suppressed in reset and while the held word is stalled.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_ch    = '0;
    if (i_rst || !w_load) begin
      w_gnt_valid = 1'b0;
    end else if (bus.MODE) begin
      w_gnt_valid = w_rr_found;
      w_gnt_ch    = w_rr_winner;
    end else begin
      w_gnt_valid = w_sel_ok ? bus.REQ[bus.S] : 1'b0;
      w_gnt_ch    = bus.S;
    end
  end

  // One-hot grant vector from the decision above (zero when no grant).
  always_comb begin
    w_gnt = '0;
    if (w_gnt_valid) begin
      w_gnt[w_gnt_ch] = 1'b1;
    end else begin
      w_gnt = '0;
    end
  end

  // Output register and round-robin pointer; pointer moves only on MODE=1 grants.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y       <= '0;
      r_y_ch    <= '0;
      r_y_valid <= 1'b0;
      r_ptr     <= '0;
    end else if (w_gnt_valid) begin
      r_y       <= bus.I[int'(w_gnt_ch)*WIDTH +: WIDTH];
      r_y_ch    <= w_gnt_ch;
      r_y_valid <= 1'b1;
      if (bus.MODE) begin
        if (int'(w_gnt_ch) == CHANNELS - 1) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_gnt_ch + SEL_W'(1);
        end
      end
    end else if (r_y_valid && bus.Y_READY) begin
      r_y_valid <= 1'b0;
    end
  end

  assign bus.GNT     = w_gnt;
  assign bus.Y       = r_y;
  assign bus.Y_VALID = r_y_valid;
  assign bus.Y_CH    = r_y_ch;

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Directed bench for mux_arb_n_to_1 (WIDTH=16, CHANNELS=8).
// Inputs change 1 time unit after a rising edge; the combinational grant is
// sampled 1 unit later, registered outputs 1 unit after the following edge.
module tb_mux_arb_n_to_1;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  logic [15:0] exp_data [8];

  mux_arb_n_to_1_if #(.WIDTH(16), .CHANNELS(8), .SEL_W(3)) bus ();

  mux_arb_n_to_1 #(.WIDTH(16), .CHANNELS(8), .SEL_W(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.REQ     = 8'h00;
    bus.Y_READY = 1'b0;
    bus.MODE    = 1'b0;
    bus.S       = 3'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.REQ     = 8'hFF;
    bus.MODE    = 1'b1;
    bus.Y_READY = 1'b1;
    #1;
    vec++;
    if (bus.GNT !== 8'h00) begin errs++; $display("FAIL rst_gnt got %h want 00", bus.GNT); end
    tick();
    vec++;
    if (bus.Y !== 16'h0000 || bus.Y_VALID !== 1'b0 || bus.Y_CH !== 3'd0) begin
      errs++; $display("FAIL rst_state got y=%h v=%b ch=%0d want 0000/0/0", bus.Y, bus.Y_VALID, bus.Y_CH);
    end
    tick();
    rst = 1'b0;
    #1;
    vec++;
    if (bus.GNT !== 8'h01) begin errs++; $display("FAIL rst_first_gnt got %h want 01", bus.GNT); end
    tick();
    vec++;
    if (bus.Y !== 16'h00DE || bus.Y_VALID !== 1'b1 || bus.Y_CH !== 3'd0) begin
      errs++; $display("FAIL rst_first_word got y=%h v=%b ch=%0d want 00DE/1/0", bus.Y, bus.Y_VALID, bus.Y_CH);
    end
  endtask

  task automatic test_direct_sweep();
    do_reset();
    bus.MODE    = 1'b0;
    bus.REQ     = 8'hFF;
    bus.Y_READY = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.S = 3'(s);
      #1;
      vec++;
      if (bus.GNT !== 8'(1 << s)) begin errs++; $display("FAIL sweep_gnt s=%0d got %h want %h", s, bus.GNT, 8'(1 << s)); end
      tick();
      vec++;
      if (bus.Y !== exp_data[s] || bus.Y_VALID !== 1'b1 || bus.Y_CH !== 3'(s)) begin
        errs++; $display("FAIL sweep_y s=%0d got y=%h v=%b ch=%0d want %h/1/%0d", s, bus.Y, bus.Y_VALID, bus.Y_CH, exp_data[s], s);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.MODE    = 1'b1;
    bus.REQ     = 8'hFF;
    bus.Y_READY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      vec++;
      if (bus.GNT !== 8'(1 << (c % 8))) begin errs++; $display("FAIL rr_gnt c=%0d got %h want %h", c, bus.GNT, 8'(1 << (c % 8))); end
      tick();
      vec++;
      if (bus.Y_CH !== 3'(c % 8) || bus.Y !== exp_data[c % 8]) begin
        errs++; $display("FAIL rr_y c=%0d got ch=%0d y=%h want %0d/%h", c, bus.Y_CH, bus.Y, c % 8, exp_data[c % 8]);
      end
    end
  endtask

  task automatic test_sparse();
    logic [2:0]  seq_ch [6];
    logic [15:0] seq_y  [6];
    seq_ch = '{3'd2, 3'd4, 3'd7, 3'd2, 3'd4, 3'd7};
    seq_y  = '{16'h009A, 16'h0056, 16'h00F0, 16'h009A, 16'h0056, 16'h00F0};
    do_reset();
    bus.MODE    = 1'b1;
    bus.REQ     = 8'b1001_0100;
    bus.Y_READY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      vec++;
      if (bus.Y_CH !== seq_ch[c] || bus.Y !== seq_y[c] || bus.Y_VALID !== 1'b1) begin
        errs++; $display("FAIL sparse c=%0d got ch=%0d y=%h v=%b want %0d/%h/1", c, bus.Y_CH, bus.Y, bus.Y_VALID, seq_ch[c], seq_y[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.MODE    = 1'b1;
    bus.REQ     = 8'hFF;
    bus.Y_READY = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    vec++;
    if (bus.Y !== 16'h0056 || bus.Y_VALID !== 1'b1) begin
      errs++; $display("FAIL bp_setup got y=%h v=%b want 0056/1", bus.Y, bus.Y_VALID);
    end
    bus.Y_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vec++;
      if (bus.GNT !== 8'h00) begin errs++; $display("FAIL bp_gnt c=%0d got %h want 00", c, bus.GNT); end
      tick();
      vec++;
      if (bus.Y !== 16'h0056 || bus.Y_VALID !== 1'b1 || bus.Y_CH !== 3'd4) begin
        errs++; $display("FAIL bp_hold c=%0d got y=%h v=%b ch=%0d want 0056/1/4", c, bus.Y, bus.Y_VALID, bus.Y_CH);
      end
    end
    bus.Y_READY = 1'b1;
    #1;
    vec++;
    if (bus.GNT !== 8'h20) begin errs++; $display("FAIL bp_release_gnt got %h want 20", bus.GNT); end
    tick();
    vec++;
    if (bus.Y !== 16'h0034 || bus.Y_CH !== 3'd5 || bus.Y_VALID !== 1'b1) begin
      errs++; $display("FAIL bp_release_y got y=%h ch=%0d v=%b want 0034/5/1", bus.Y, bus.Y_CH, bus.Y_VALID);
    end
  endtask

  // Continues from backpressure: word from channel 5 held, pointer at 6.
  task automatic test_invalid_select();
    bus.MODE = 1'b0;
    bus.S    = 3'd7;
    bus.REQ  = 8'h7F;
    #1;
    vec++;
    if (bus.GNT !== 8'h00) begin errs++; $display("FAIL inv_gnt got %h want 00", bus.GNT); end
    tick();
    vec++;
    if (bus.Y_VALID !== 1'b0 || bus.Y !== 16'h0034 || bus.Y_CH !== 3'd5) begin
      errs++; $display("FAIL inv_drain got v=%b y=%h ch=%0d want 0/0034/5", bus.Y_VALID, bus.Y, bus.Y_CH);
    end
    bus.REQ = 8'hFF;
    #1;
    vec++;
    if (bus.GNT !== 8'h80) begin errs++; $display("FAIL inv_gnt7 got %h want 80", bus.GNT); end
    tick();
    vec++;
    if (bus.Y !== 16'h00F0 || bus.Y_CH !== 3'd7 || bus.Y_VALID !== 1'b1) begin
      errs++; $display("FAIL inv_y7 got y=%h ch=%0d v=%b want 00F0/7/1", bus.Y, bus.Y_CH, bus.Y_VALID);
    end
    bus.MODE = 1'b1;
    #1;
    vec++;
    if (bus.GNT !== 8'h40) begin errs++; $display("FAIL ptr_kept_gnt got %h want 40", bus.GNT); end
    tick();
    vec++;
    if (bus.Y_CH !== 3'd6 || bus.Y !== 16'h0012) begin
      errs++; $display("FAIL ptr_kept_y got ch=%0d y=%h want 6/0012", bus.Y_CH, bus.Y);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.MODE    = 1'b1;
    bus.REQ     = 8'hFF;
    bus.Y_READY = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    #1;
    vec++;
    if (bus.GNT !== 8'h00) begin errs++; $display("FAIL mid_rst_gnt got %h want 00", bus.GNT); end
    tick();
    vec++;
    if (bus.Y !== 16'h0000 || bus.Y_VALID !== 1'b0 || bus.Y_CH !== 3'd0) begin
      errs++; $display("FAIL mid_rst_state got y=%h v=%b ch=%0d want 0000/0/0", bus.Y, bus.Y_VALID, bus.Y_CH);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (bus.GNT !== 8'h01) begin errs++; $display("FAIL mid_rst_first_gnt got %h want 01", bus.GNT); end
    tick();
    vec++;
    if (bus.Y !== 16'h00DE || bus.Y_CH !== 3'd0 || bus.Y_VALID !== 1'b1) begin
      errs++; $display("FAIL mid_rst_first_y got y=%h ch=%0d v=%b want 00DE/0/1", bus.Y, bus.Y_CH, bus.Y_VALID);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    exp_data = '{16'h00DE, 16'h00BC, 16'h009A, 16'h0078, 16'h0056, 16'h0034, 16'h0012, 16'h00F0};
    bus.I       = {16'h00F0, 16'h0012, 16'h0034, 16'h0056, 16'h0078, 16'h009A, 16'h00BC, 16'h00DE};
    bus.REQ     = 8'h00;
    bus.S       = 3'd0;
    bus.MODE    = 1'b0;
    bus.Y_READY = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_direct_sweep();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_invalid_select();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
